// File: rtl/mcdf_pkt_arbiter.sv
// Packet arbiter: picks the lowest-priority-value channel holding a full packet (round-robin
// among equals), requests the formatter bus, then streams the packet one word per cycle.
module mcdf_pkt_arbiter #(
  parameter int NCH = 3,
  parameter int DW  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NCH-1:0]    slv_en,
  input  logic [2*NCH-1:0]  slv_prio,
  input  logic [3*NCH-1:0]  slv_len,
  input  logic [NCH-1:0]    slv_req,
  input  logic [DW*NCH-1:0] slv_data,
  output logic [NCH-1:0]    slv_ack,
  output logic              fmt_req,
  output logic [1:0]        fmt_chid,
  output logic [5:0]        fmt_length,
  input  logic              fmt_grant,
  output logic [DW-1:0]     fmt_data,
  output logic              fmt_start,
  output logic              fmt_end,
  output logic              arb_busy
);

  typedef enum logic [1:0] {IDLE, REQ, SEND} state_t;

  state_t         state;
  logic [1:0]     sel;
  logic [1:0]     last_ch;
  logic [5:0]     cnt;
  logic [5:0]     len_q;
  logic           first;

  logic [NCH-1:0] cand;
  logic           found;
  logic [1:0]     best_prio;
  logic [1:0]     pick;
  logic [1:0]     idx;
  logic [5:0]     pick_len;

  function automatic logic [5:0] decode_len(input logic [2:0] code);
    case (code)
      3'd0:    return 6'd4;
      3'd1:    return 6'd8;
      3'd2:    return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  // Scan in round-robin order from last_ch+1; only a strictly lower priority value
  // displaces the current pick, so the first equal-priority channel in scan order wins.
  always_comb begin
    cand      = slv_req & slv_en;
    found     = 1'b0;
    best_prio = 2'd0;
    pick      = 2'd0;
    idx       = 2'd0;
    for (int k = 1; k <= NCH; k++) begin
      idx = 2'((int'(last_ch) + k) % NCH);
      if (cand[idx] && (!found || slv_prio[2*idx +: 2] < best_prio)) begin
        found     = 1'b1;
        best_prio = slv_prio[2*idx +: 2];
        pick      = idx;
      end
    end
    pick_len = decode_len(slv_len[3*pick +: 3]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      sel     <= 2'd0;
      len_q   <= 6'd0;
      cnt     <= 6'd0;
      first   <= 1'b0;
      last_ch <= 2'(NCH-1);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            sel   <= pick;
            len_q <= pick_len;
            cnt   <= pick_len;
            state <= REQ;
          end
        end
        REQ: begin
          if (fmt_grant) begin
            state   <= SEND;
            first   <= 1'b1;
            last_ch <= sel;
          end
        end
        SEND: begin
          first <= 1'b0;
          cnt   <= cnt - 6'd1;
          if (cnt == 6'd1) begin
            state <= IDLE;
            sel   <= 2'd0;
            len_q <= 6'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fmt_req    = (state == REQ);
  assign fmt_chid   = sel;
  assign fmt_length = len_q;
  assign fmt_start  = first;
  assign fmt_end    = (state == SEND) && (cnt == 6'd1);
  assign arb_busy   = (state != IDLE);
  assign fmt_data   = (state == SEND) ? slv_data[DW*int'(sel) +: DW] : '0;

  always_comb begin
    slv_ack = '0;
    for (int i = 0; i < NCH; i++) begin
      slv_ack[i] = (state == SEND) && (sel == 2'(i));
    end
  end

endmodule

// File: tb/tb_mcdf_pkt_arbiter.sv
// Directed bench for mcdf_pkt_arbiter: FIFO heads are modelled as per-channel sequence counters.
module tb_mcdf_pkt_arbiter;

  logic        clk;
  logic        rstn;
  logic [2:0]  slv_en;
  logic [5:0]  slv_prio;
  logic [8:0]  slv_len;
  logic [2:0]  slv_req;
  logic [95:0] slv_data;
  logic [2:0]  slv_ack;
  logic        fmt_req;
  logic [1:0]  fmt_chid;
  logic [5:0]  fmt_length;
  logic        fmt_grant;
  logic [31:0] fmt_data;
  logic        fmt_start;
  logic        fmt_end;
  logic        arb_busy;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] seq [3] = '{default: 16'd0};
  int          exp_seq [3] = '{default: 0};

  mcdf_pkt_arbiter #(.NCH(3), .DW(32)) dut (
    .clk(clk), .rstn(rstn), .slv_en(slv_en), .slv_prio(slv_prio), .slv_len(slv_len),
    .slv_req(slv_req), .slv_data(slv_data), .slv_ack(slv_ack), .fmt_req(fmt_req),
    .fmt_chid(fmt_chid), .fmt_length(fmt_length), .fmt_grant(fmt_grant),
    .fmt_data(fmt_data), .fmt_start(fmt_start), .fmt_end(fmt_end), .arb_busy(arb_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] head_word(input int ch, input logic [15:0] s);
    return {8'hC0, 6'd0, 2'(ch), s};
  endfunction

  // Show-ahead FIFO heads: each ack pops one word.
  always_comb begin
    slv_data = '0;
    for (int i = 0; i < 3; i++) slv_data[i*32 +: 32] = head_word(i, seq[i]);
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) if (slv_ack[i]) seq[i] <= seq[i] + 16'd1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk(tag, {slv_ack, fmt_req, fmt_chid, fmt_length, fmt_start, fmt_end, arb_busy, fmt_data}, 64'd0);
  endtask

  // Waits for fmt_req, grants after gdly cycles, checks every word; abort>0 returns after that many words.
  task automatic run_pkt(input int ch, input int len, input int gdly, input int exp_wait, input int abort);
    int n;
    logic [13:0] ce;
    logic [13:0] ca;
    n = 0;
    while (fmt_req !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (fmt_req !== 1'b1) begin
      chk("req_seen", fmt_req, 1);
      return;
    end
    if (exp_wait >= 0) chk("req_gap", n, exp_wait);
    chk("req_chid", fmt_chid, ch);
    chk("req_length", fmt_length, len);
    for (int d = 0; d < gdly; d++) begin
      chk("stall", {fmt_req, slv_ack, fmt_start, fmt_chid, fmt_length}, {1'b1, 3'b000, 1'b0, 2'(ch), 6'(len)});
      @(negedge clk);
    end
    fmt_grant = 1'b1;
    @(negedge clk);
    fmt_grant = 1'b0;
    for (int k = 0; k < len; k++) begin
      if (abort > 0 && k == abort) return;
      if (k > 0) @(negedge clk);
      chk("word_data", fmt_data, head_word(ch, 16'(exp_seq[ch])));
      exp_seq[ch]++;
      ca = {fmt_start, fmt_end, slv_ack, fmt_req, fmt_chid, fmt_length};
      ce = {k == 0, k == len - 1, 3'(1 << ch), 1'b0, 2'(ch), 6'(len)};
      chk("word_ctrl", ca, ce);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rstn = 1'b0; fmt_grant = 1'b0;
    slv_en = 3'b000; slv_req = 3'b000; slv_prio = 6'd0; slv_len = 9'd0;
    #3;
    check_zero("reset_outputs");
    @(negedge clk);
    rstn = 1'b1;

    // Round-robin at equal priority, 8-word packets: 0,1,2,0
    slv_en = 3'b111; slv_prio = 6'b01_01_01; slv_len = 9'b001_001_001; slv_req = 3'b111;
    run_pkt(0, 8, 0, -1, 0);
    run_pkt(1, 8, 0, 2, 0);
    run_pkt(2, 8, 0, 2, 0);
    run_pkt(0, 8, 0, 2, 0);
    slv_req = 3'b000;
    repeat (3) @(negedge clk);

    // Single ch1 packet, 4 words
    slv_prio = 6'd0; slv_len = 9'd0; slv_req = 3'b010;
    run_pkt(1, 4, 0, -1, 0);
    slv_req = 3'b000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_busy", arb_busy, 0);
    end

    // Priority: ch2 (prio 1) before ch0 (prio 2)
    slv_prio = 6'b01_00_10; slv_req = 3'b101;
    run_pkt(2, 4, 0, -1, 0);
    slv_req = 3'b001;
    run_pkt(0, 4, 0, 2, 0);
    slv_req = 3'b000;
    repeat (3) @(negedge clk);

    // Grant held low 10 cycles
    slv_prio = 6'd0; slv_req = 3'b001;
    run_pkt(0, 4, 10, -1, 0);
    slv_req = 3'b000;
    repeat (3) @(negedge clk);

    // Reset after word 2 of an 8-word ch0 packet
    slv_len = 9'b000_000_001; slv_req = 3'b001;
    run_pkt(0, 8, 0, -1, 2);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1 check_zero("mid_reset_async");
    @(negedge clk);
    check_zero("mid_reset_held");
    rstn = 1'b1;
    slv_prio = 6'd0; slv_len = 9'd0; slv_req = 3'b011;
    run_pkt(0, 4, 0, -1, 0);
    slv_req = 3'b000;
    repeat (3) @(negedge clk);

    // Disabled channel is never selected
    slv_en = 3'b011; slv_req = 3'b100;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("disabled_busy", arb_busy, 0);
    end

    // Length code 5 -> 32 words; second packet survives mid-packet len/req changes
    slv_en = 3'b111; slv_len = 9'b101_000_000;
    run_pkt(2, 32, 0, -1, 0);
    fork
      run_pkt(2, 32, 0, 2, 0);
      begin
        n = 0;
        while (fmt_start !== 1'b1 && n < 200) begin
          @(negedge clk);
          n++;
        end
        repeat (5) @(negedge clk);
        slv_len = 9'd0;
        slv_req = 3'b000;
      end
    join
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("final_idle", {arb_busy, slv_ack}, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
